// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - Fetch, load/store and memory-macro signals of the unified memory port arbiter
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 10
);
    logic                  if_req;
    logic [31:0]           if_addr;
    logic                  if_gnt;
    logic                  if_rvalid;
    logic [31:0]           if_rdata;

    logic                  d_req;
    logic                  d_we;
    logic [3:0]            d_be;
    logic [31:0]           d_addr;
    logic [31:0]           d_wdata;
    logic                  d_gnt;
    logic                  d_rvalid;
    logic [31:0]           d_rdata;
    logic                  d_err;

    logic                  mem_en;
    logic                  mem_we;
    logic [3:0]            mem_be;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic [31:0]           mem_rdata;

    // Core and memory macro side
    modport master (
        output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, d_err,
        input  mem_en, mem_we, mem_be, mem_addr, mem_wdata
    );

    // Arbiter side
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, d_err,
        output mem_en, mem_we, mem_be, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - Shares one synchronous-read memory between instruction fetch and load/store
// Data has priority; fetch overrides it after MAX_WAIT consecutive unserved request cycles.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int MAX_WAIT   = 4
) (
    input logic               clk,
    input logic               reset,
    mem_port_arbiter_if.slave bus
);
    localparam logic [2:0] OWN_NONE  = 3'd0;
    localparam logic [2:0] OWN_IF    = 3'd1;
    localparam logic [2:0] OWN_LOAD  = 3'd2;
    localparam logic [2:0] OWN_STORE = 3'd3;
    localparam logic [2:0] OWN_ERR   = 3'd4;

    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_max_wait
        $error("mem_port_arbiter: MAX_WAIT must be in 1..15");
    end
    if (ADDR_WIDTH < 1 || ADDR_WIDTH > 29) begin : g_bad_addr_width
        $error("mem_port_arbiter: ADDR_WIDTH must be in 1..29");
    end

    logic [3:0]  starve_cnt;
    logic [2:0]  owner;
    logic [2:0]  owner_next;
    logic [31:0] if_rdata_q;
    logic [31:0] d_rdata_q;
    logic [31:0] if_rdata_w;
    logic [31:0] d_rdata_w;
    logic        if_win;
    logic        d_win;
    logic        d_misaligned;
    logic        if_rvalid_w;
    logic        d_rvalid_w;
    logic        unused_addr_bits;

    // Upper address bits wrap; fetch alignment is guaranteed by the core.
    assign unused_addr_bits = ^{bus.if_addr[31:ADDR_WIDTH+2], bus.if_addr[1:0],
                                bus.d_addr[31:ADDR_WIDTH+2]};

    assign d_misaligned = (bus.d_addr[1:0] != 2'b00);

    always_comb begin
        if_win = 1'b0;
        d_win  = 1'b0;
        if (reset) begin
            if_win = bus.if_req && (!bus.d_req || (starve_cnt >= WAIT_LIMIT));
            d_win  = bus.d_req && !if_win;
        end
    end

    assign bus.if_gnt = if_win;
    assign bus.d_gnt  = d_win;

    // A misaligned data grant is accepted but never reaches the memory.
    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_be    = 4'b0000;
        bus.mem_addr  = '0;
        bus.mem_wdata = 32'h0;
        if (if_win) begin
            bus.mem_en   = 1'b1;
            bus.mem_addr = bus.if_addr[ADDR_WIDTH+1:2];
        end else if (d_win && !d_misaligned) begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = bus.d_we;
            bus.mem_be    = bus.d_we ? bus.d_be : 4'b0000;
            bus.mem_addr  = bus.d_addr[ADDR_WIDTH+1:2];
            bus.mem_wdata = bus.d_wdata;
        end
    end

    always_comb begin
        owner_next = OWN_NONE;
        if (if_win) begin
            owner_next = OWN_IF;
        end else if (d_win) begin
            if (d_misaligned) begin
                owner_next = OWN_ERR;
            end else if (bus.d_we) begin
                owner_next = OWN_STORE;
            end else begin
                owner_next = OWN_LOAD;
            end
        end
    end

    // Responses are combinational from the owner so registered macro data returns in the same cycle.
    always_comb begin
        if_rvalid_w = (owner == OWN_IF);
        d_rvalid_w  = (owner == OWN_LOAD) || (owner == OWN_STORE) || (owner == OWN_ERR);
        if_rdata_w  = if_rvalid_w ? bus.mem_rdata : if_rdata_q;
        d_rdata_w   = d_rdata_q;
        if (owner == OWN_LOAD) begin
            d_rdata_w = bus.mem_rdata;
        end else if (d_rvalid_w) begin
            d_rdata_w = 32'h0;
        end
    end

    assign bus.if_rvalid = if_rvalid_w;
    assign bus.if_rdata  = if_rdata_w;
    assign bus.d_rvalid  = d_rvalid_w;
    assign bus.d_rdata   = d_rdata_w;
    assign bus.d_err     = (owner == OWN_ERR);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner      <= OWN_NONE;
            starve_cnt <= 4'd0;
            if_rdata_q <= 32'h0;
            d_rdata_q  <= 32'h0;
        end else begin
            owner      <= owner_next;
            if_rdata_q <= if_rdata_w;
            d_rdata_q  <= d_rdata_w;
            if (!bus.if_req || if_win) begin
                starve_cnt <= 4'd0;
            end else if (starve_cnt != 4'hF) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - Scoreboard testbench for mem_port_arbiter with a synchronous-read memory model
module tb_mem_port_arbiter;
    localparam int AW = 10;
    localparam int MW = 4;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dreq_t;

    logic clk = 1'b0;
    logic reset;
    logic mem_load;
    logic [31:0] mem [0:1023];
    logic [31:0] mem_rdata_r;
    logic [31:0] ref_mem [0:1023];
    logic [31:0] exp_if_q [$];
    logic [32:0] exp_d_q [$];
    int checks_total = 0;
    int checks_passed = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

    mem_port_arbiter #(.ADDR_WIDTH(AW), .MAX_WAIT(MW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [31:0] init_word(input int i);
        logic [15:0] k;
        k = i[15:0];
        if (i == 2) return 32'h00100113;
        if (i == 64) return 32'h00000032;
        return {k ^ 16'hA5A5, k ^ 16'h0F0F};
    endfunction

    assign bus.mem_rdata = mem_rdata_r;

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
            mem_rdata_r <= 32'h0;
        end else if (bus.mem_en) begin
            if (bus.mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (bus.mem_be[b]) mem[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
            end else begin
                mem_rdata_r <= mem[bus.mem_addr];
            end
        end
    end

    task automatic idle_inputs();
        bus.if_req = 1'b0; bus.if_addr = 32'h0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_be = 4'h0; bus.d_addr = 32'h0; bus.d_wdata = 32'h0;
    endtask

    task automatic drive_data(input dreq_t r);
        bus.d_req = 1'b1; bus.d_we = r.we; bus.d_be = r.be; bus.d_addr = r.addr; bus.d_wdata = r.wdata;
    endtask

    task automatic test_reset();
        bus.if_req = 1'b1; bus.if_addr = 32'h8;
        drive_data('{we: 1'b1, be: 4'hF, addr: 32'h10, wdata: 32'h12345678});
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks_total++;
        if ({bus.if_gnt, bus.d_gnt} !== 2'b00) $display("FAIL reset_gnt: got %b expected 00", {bus.if_gnt, bus.d_gnt});
        else checks_passed++;
        checks_total++;
        if ({bus.mem_en, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata} !== '0)
            $display("FAIL reset_mem: got en=%b we=%b be=%h addr=%h wdata=%h expected all 0", bus.mem_en, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata);
        else checks_passed++;
        checks_total++;
        if ({bus.if_rvalid, bus.d_rvalid, bus.d_err} !== 3'b000) $display("FAIL reset_rvalid: got %b expected 000", {bus.if_rvalid, bus.d_rvalid, bus.d_err});
        else checks_passed++;
        checks_total++;
        if ({bus.if_rdata, bus.d_rdata} !== 64'h0) $display("FAIL reset_rdata: got %h expected 0", {bus.if_rdata, bus.d_rdata});
        else checks_passed++;
        @(posedge clk); #1;
        mem_load = 1'b0; reset = 1'b1; idle_inputs();
        @(negedge clk);
        checks_total++;
        if ({bus.if_rvalid, bus.d_rvalid, bus.if_gnt, bus.d_gnt, bus.mem_en} !== 5'b0)
            $display("FAIL reset_release: got %b expected 00000", {bus.if_rvalid, bus.d_rvalid, bus.if_gnt, bus.d_gnt, bus.mem_en});
        else checks_passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_fetch_only();
        logic [31:0] e;
        bus.if_req = 1'b1; bus.if_addr = 32'h8;
        exp_if_q.push_back(32'h00100113);
        @(negedge clk);
        checks_total++;
        if ({bus.if_gnt, bus.d_gnt, bus.mem_en, bus.mem_we, bus.mem_be, bus.mem_addr} !== {1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 10'd2})
            $display("FAIL fetch_grant: got gnt=%b%b en=%b we=%b be=%h addr=%0d expected 10 1 0 0 2", bus.if_gnt, bus.d_gnt, bus.mem_en, bus.mem_we, bus.mem_be, bus.mem_addr);
        else checks_passed++;
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        e = exp_if_q.pop_front();
        checks_total++;
        if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== e) $display("FAIL fetch_resp: got rvalid=%b rdata=%h expected 1 %h", bus.if_rvalid, bus.if_rdata, e);
        else checks_passed++;
        checks_total++;
        if ({bus.d_rvalid, bus.if_gnt, bus.d_gnt, bus.mem_en} !== 4'b0) $display("FAIL fetch_idle: got %b expected 0000", {bus.d_rvalid, bus.if_gnt, bus.d_gnt, bus.mem_en});
        else checks_passed++;
        @(posedge clk); #1;
        @(negedge clk);
        checks_total++;
        if (bus.if_rvalid !== 1'b0 || bus.if_rdata !== 32'h00100113) $display("FAIL fetch_hold: got rvalid=%b rdata=%h expected 0 00100113", bus.if_rvalid, bus.if_rdata);
        else checks_passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_store_load();
        logic [32:0] ed;
        drive_data('{we: 1'b1, be: 4'b0011, addr: 32'h10, wdata: 32'hAABBCCDD});
        @(negedge clk);
        checks_total++;
        if ({bus.if_gnt, bus.d_gnt, bus.mem_en, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata} !== {1'b0, 1'b1, 1'b1, 1'b1, 4'b0011, 10'd4, 32'hAABBCCDD})
            $display("FAIL store_grant: got gnt=%b en=%b we=%b be=%b addr=%0d wdata=%h expected d_gnt, 1 1 0011 4 aabbccdd", bus.d_gnt, bus.mem_en, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata);
        else checks_passed++;
        ref_mem[4][15:0] = 16'hCCDD;
        exp_d_q.push_back({1'b0, 32'h0});
        @(posedge clk); #1;
        drive_data('{we: 1'b0, be: 4'b1111, addr: 32'h10, wdata: 32'h0});
        @(negedge clk);
        ed = exp_d_q.pop_front();
        checks_total++;
        if (bus.d_rvalid !== 1'b1 || {bus.d_err, bus.d_rdata} !== ed) $display("FAIL store_resp: got rvalid=%b err=%b rdata=%h expected 1 %h", bus.d_rvalid, bus.d_err, bus.d_rdata, ed);
        else checks_passed++;
        checks_total++;
        if ({bus.d_gnt, bus.mem_en, bus.mem_we, bus.mem_be, bus.mem_addr} !== {1'b1, 1'b1, 1'b0, 4'b0000, 10'd4})
            $display("FAIL load_grant: got gnt=%b en=%b we=%b be=%b addr=%0d expected 1 1 0 0000 4", bus.d_gnt, bus.mem_en, bus.mem_we, bus.mem_be, bus.mem_addr);
        else checks_passed++;
        exp_d_q.push_back({1'b0, ref_mem[4]});
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        ed = exp_d_q.pop_front();
        checks_total++;
        if (bus.d_rvalid !== 1'b1 || {bus.d_err, bus.d_rdata} !== ed || bus.d_rdata[15:0] !== 16'hCCDD)
            $display("FAIL load_merged: got rvalid=%b err=%b rdata=%h expected 1 %h", bus.d_rvalid, bus.d_err, bus.d_rdata, ed);
        else checks_passed++;
        @(posedge clk); #1;
        @(negedge clk);
        checks_total++;
        if (bus.d_rvalid !== 1'b0 || bus.d_rdata !== ref_mem[4]) $display("FAIL load_hold: got rvalid=%b rdata=%h expected 0 %h", bus.d_rvalid, bus.d_rdata, ref_mem[4]);
        else checks_passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_misaligned();
        logic [32:0] ed;
        drive_data('{we: 1'b0, be: 4'h0, addr: 32'h13, wdata: 32'h0});
        @(negedge clk);
        checks_total++;
        if ({bus.d_gnt, bus.if_gnt, bus.mem_en} !== 3'b100) $display("FAIL misaligned_load_grant: got d_gnt,if_gnt,mem_en=%b expected 100", {bus.d_gnt, bus.if_gnt, bus.mem_en});
        else checks_passed++;
        exp_d_q.push_back({1'b1, 32'h0});
        @(posedge clk); #1;
        drive_data('{we: 1'b1, be: 4'hF, addr: 32'h22, wdata: 32'hDEADBEEF});
        @(negedge clk);
        ed = exp_d_q.pop_front();
        checks_total++;
        if (bus.d_rvalid !== 1'b1 || {bus.d_err, bus.d_rdata} !== ed) $display("FAIL misaligned_load_resp: got rvalid=%b err=%b rdata=%h expected 1 %h", bus.d_rvalid, bus.d_err, bus.d_rdata, ed);
        else checks_passed++;
        checks_total++;
        if ({bus.d_gnt, bus.mem_en} !== 2'b10) $display("FAIL misaligned_store_grant: got d_gnt,mem_en=%b expected 10", {bus.d_gnt, bus.mem_en});
        else checks_passed++;
        exp_d_q.push_back({1'b1, 32'h0});
        @(posedge clk); #1;
        drive_data('{we: 1'b0, be: 4'h0, addr: 32'h20, wdata: 32'h0});
        @(negedge clk);
        ed = exp_d_q.pop_front();
        checks_total++;
        if (bus.d_rvalid !== 1'b1 || {bus.d_err, bus.d_rdata} !== ed) $display("FAIL misaligned_store_resp: got rvalid=%b err=%b rdata=%h expected 1 %h", bus.d_rvalid, bus.d_err, bus.d_rdata, ed);
        else checks_passed++;
        exp_d_q.push_back({1'b0, ref_mem[8]});
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        ed = exp_d_q.pop_front();
        checks_total++;
        if (bus.d_rvalid !== 1'b1 || {bus.d_err, bus.d_rdata} !== ed) $display("FAIL misaligned_no_write: got rvalid=%b err=%b rdata=%h expected 1 %h", bus.d_rvalid, bus.d_err, bus.d_rdata, ed);
        else checks_passed++;
        @(posedge clk); #1;
        @(negedge clk);
        checks_total++;
        if ({bus.d_rvalid, bus.d_err} !== 2'b00) $display("FAIL misaligned_clear: got rvalid,err=%b expected 00", {bus.d_rvalid, bus.d_err});
        else checks_passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_arbitration();
        logic [31:0] fq [$];
        dreq_t dq [$];
        int f_cyc [$];
        int m_cnt;
        int cyc;
        logic f_act, d_act, fwin, dwin, if_pend, d_pend;
        logic [AW-1:0] exp_addr;
        logic [AW-1:0] idx;
        logic [31:0] e;
        logic [32:0] ed;
        for (int s = 0; s < 2; s++) begin
            fq.delete(); dq.delete(); f_cyc.delete();
            if (s == 0) begin
                fq.push_back(32'h0C);
                dq.push_back('{we: 1'b0, be: 4'h0, addr: 32'h100, wdata: 32'h0});
            end else begin
                fq.push_back(32'h0C);
                fq.push_back(32'h1008);
                dq.push_back('{we: 1'b0, be: 4'h0, addr: 32'h100, wdata: 32'h0});
                dq.push_back('{we: 1'b0, be: 4'h0, addr: 32'h104, wdata: 32'h0});
                dq.push_back('{we: 1'b1, be: 4'b1100, addr: 32'h18, wdata: 32'h11223344});
                dq.push_back('{we: 1'b0, be: 4'h0, addr: 32'h18, wdata: 32'h0});
                dq.push_back('{we: 1'b0, be: 4'h0, addr: 32'h20000108, wdata: 32'h0});
                dq.push_back('{we: 1'b1, be: 4'b1111, addr: 32'h1C, wdata: 32'hCAFEF00D});
                dq.push_back('{we: 1'b0, be: 4'h0, addr: 32'h1C, wdata: 32'h0});
                dq.push_back('{we: 1'b0, be: 4'h0, addr: 32'h100, wdata: 32'h0});
                dq.push_back('{we: 1'b0, be: 4'h0, addr: 32'h0C, wdata: 32'h0});
            end
            m_cnt = 0; cyc = 0; if_pend = 1'b0; d_pend = 1'b0;
            while ((fq.size() != 0 || dq.size() != 0 || if_pend || d_pend) && cyc < 40) begin
                f_act = (fq.size() != 0);
                d_act = (dq.size() != 0);
                idle_inputs();
                if (f_act) begin bus.if_req = 1'b1; bus.if_addr = fq[0]; end
                if (d_act) drive_data(dq[0]);
                @(negedge clk);
                checks_total++;
                if (if_pend) begin
                    e = exp_if_q.pop_front();
                    if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== e) $display("FAIL arb_if_resp: cycle %0d got rvalid=%b rdata=%h expected 1 %h", cyc, bus.if_rvalid, bus.if_rdata, e);
                    else checks_passed++;
                end else if (bus.if_rvalid !== 1'b0) $display("FAIL arb_if_spurious: cycle %0d got rvalid=1 expected 0", cyc);
                else checks_passed++;
                checks_total++;
                if (d_pend) begin
                    ed = exp_d_q.pop_front();
                    if (bus.d_rvalid !== 1'b1 || {bus.d_err, bus.d_rdata} !== ed) $display("FAIL arb_d_resp: cycle %0d got rvalid=%b err=%b rdata=%h expected 1 %h", cyc, bus.d_rvalid, bus.d_err, bus.d_rdata, ed);
                    else checks_passed++;
                end else if (bus.d_rvalid !== 1'b0) $display("FAIL arb_d_spurious: cycle %0d got rvalid=1 expected 0", cyc);
                else checks_passed++;
                fwin = f_act && (!d_act || m_cnt >= MW);
                dwin = d_act && !fwin;
                exp_addr = fwin ? fq[0][AW+1:2] : (dwin ? dq[0].addr[AW+1:2] : '0);
                checks_total++;
                if ({bus.if_gnt, bus.d_gnt, bus.mem_addr} !== {fwin, dwin, exp_addr})
                    $display("FAIL arb_grant: cycle %0d got if_gnt=%b d_gnt=%b addr=%0d expected %b %b %0d", cyc, bus.if_gnt, bus.d_gnt, bus.mem_addr, fwin, dwin, exp_addr);
                else checks_passed++;
                if (bus.if_gnt === 1'b1) f_cyc.push_back(cyc);
                if_pend = fwin;
                d_pend = dwin;
                if (fwin) begin
                    idx = fq[0][AW+1:2];
                    exp_if_q.push_back(ref_mem[idx]);
                    void'(fq.pop_front());
                end
                if (dwin) begin
                    idx = dq[0].addr[AW+1:2];
                    if (dq[0].we) begin
                        for (int b = 0; b < 4; b++)
                            if (dq[0].be[b]) ref_mem[idx][8*b +: 8] = dq[0].wdata[8*b +: 8];
                        exp_d_q.push_back({1'b0, 32'h0});
                    end else begin
                        exp_d_q.push_back({1'b0, ref_mem[idx]});
                    end
                    void'(dq.pop_front());
                end
                m_cnt = (!f_act || fwin) ? 0 : ((m_cnt == 15) ? 15 : m_cnt + 1);
                @(posedge clk); #1;
                cyc++;
            end
            checks_total++;
            if (cyc >= 40) $display("FAIL arb_timeout: scenario %0d still pending after %0d cycles", s, cyc);
            else checks_passed++;
            checks_total++;
            if (s == 0) begin
                if (f_cyc.size() != 1 || f_cyc[0] != 1) $display("FAIL arb_simultaneous: fetch granted %0d times, first at %0d, expected once at cycle 1", f_cyc.size(), (f_cyc.size() != 0) ? f_cyc[0] : -1);
                else checks_passed++;
            end else begin
                if (f_cyc.size() != 2 || f_cyc[0] != MW || f_cyc[1] != 2*MW+1)
                    $display("FAIL arb_starvation: fetch grants %0d, at %0d/%0d, expected 2 at %0d/%0d", f_cyc.size(), (f_cyc.size() > 0) ? f_cyc[0] : -1, (f_cyc.size() > 1) ? f_cyc[1] : -1, MW, 2*MW+1);
                else checks_passed++;
            end
        end
        idle_inputs();
    endtask

    task automatic test_fetch_drop();
        logic [1:0] eg;
        drive_data('{we: 1'b0, be: 4'h0, addr: 32'h40, wdata: 32'h0});
        for (int k = 0; k < 9; k++) begin
            bus.if_req = (k != 3);
            bus.if_addr = 32'h4;
            @(negedge clk);
            eg = (k == 8) ? 2'b10 : 2'b01;
            checks_total++;
            if ({bus.if_gnt, bus.d_gnt} !== eg) $display("FAIL fetch_drop_grant: step %0d got if_gnt,d_gnt=%b expected %b", k, {bus.if_gnt, bus.d_gnt}, eg);
            else checks_passed++;
            @(posedge clk); #1;
        end
        idle_inputs();
        @(negedge clk);
        checks_total++;
        if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== ref_mem[1]) $display("FAIL fetch_drop_resp: got rvalid=%b rdata=%h expected 1 %h", bus.if_rvalid, bus.if_rdata, ref_mem[1]);
        else checks_passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midop();
        bus.if_req = 1'b1; bus.if_addr = 32'h8;
        @(negedge clk);
        checks_total++;
        if (bus.if_gnt !== 1'b1) $display("FAIL midop_grant: got if_gnt=%b expected 1", bus.if_gnt);
        else checks_passed++;
        reset = 1'b0;
        #1;
        checks_total++;
        if ({bus.if_gnt, bus.mem_en} !== 2'b00) $display("FAIL midop_gate: got if_gnt,mem_en=%b expected 00", {bus.if_gnt, bus.mem_en});
        else checks_passed++;
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        checks_total++;
        if (bus.if_rvalid !== 1'b0) $display("FAIL midop_discard: got if_rvalid=%b expected 0", bus.if_rvalid);
        else checks_passed++;
        @(posedge clk); #1;
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks_total++;
            if ({bus.if_rvalid, bus.d_rvalid, bus.d_err, bus.if_gnt, bus.d_gnt, bus.mem_en, bus.if_rdata, bus.d_rdata} !== '0)
                $display("FAIL midop_quiet: step %0d got rvalid=%b%b err=%b gnt=%b%b en=%b if_rdata=%h d_rdata=%h expected all 0", k, bus.if_rvalid, bus.d_rvalid, bus.d_err, bus.if_gnt, bus.d_gnt, bus.mem_en, bus.if_rdata, bus.d_rdata);
            else checks_passed++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset = 1'b0;
        mem_load = 1'b1;
        idle_inputs();
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
        test_reset();
        test_fetch_only();
        test_store_load();
        test_misaligned();
        test_arbitration();
        test_fetch_drop();
        test_reset_midop();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule
